// File: rtl/fp32_sub_seq_if.sv
// Handshake bundle for the sequential FP32 subtractor.
//   in_valid/in_ready : operand handshake, a = minuend, b = subtrahend
//   out_valid/out_ready : result handshake, diff = a - b
// master modport is the producer/consumer side, slave modport is the subtractor.
interface fp32_sub_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff
    );
endinterface

// File: rtl/fp32_sub_seq.sv
// Multi-cycle FP32 subtractor (diff = a - b) for the neuron leak/decrement path.
// Arithmetic: truncating, hidden bit is 0 when the exponent field is 0, no NaN/Inf handling.
// Normalization runs iteratively, NORM_BITS single-bit steps per cycle.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : fp32_sub_seq_if.slave (in_valid/in_ready/a/b, out_valid/out_ready/diff)
// Build option: define FP_SUB_SAT_EN to saturate to +/- max finite when the
// add carry pushes the exponent to 255 or beyond; otherwise the exponent wraps mod 256.
module fp32_sub_seq #(
    parameter int unsigned NORM_BITS = 1  // 1, 2, 4 or 8
) (
    input logic           clk,
    input logic           rst,
    fp32_sub_seq_if.slave bus
);

`ifdef FP_SUB_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StAlign, StArith, StNorm, StPack, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [23:0] ma_q, ma_d, mb_q, mb_d;    // aligned magnitudes
    logic        sa_q, sa_d, sb_q, sb_d;    // sign of a, effective sign of b
    logic [7:0]  exp_q, exp_d;
    logic [23:0] man_q, man_d;
    logic        sign_q, sign_d;
    logic        done_q, done_d;            // skip normalization (zero or special)
    logic        ovf_q, ovf_d;              // carry pushed exponent to >= 255
    logic        special_q, special_d;
    logic [31:0] spec_res_q, spec_res_d;
    logic [31:0] diff_q, diff_d;

    logic [7:0]  ea, eb, ediff, ne;
    logic [23:0] ma, mb, nm;
    logic [24:0] sum;

    assign ea = a_q[30:23];
    assign eb = b_q[30:23];
    assign ma = {|ea, a_q[22:0]};
    assign mb = {|eb, b_q[22:0]};

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        ma_d       = ma_q;
        mb_d       = mb_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        exp_d      = exp_q;
        man_d      = man_q;
        sign_d     = sign_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        diff_d     = diff_q;
        ediff      = '0;
        sum        = '0;
        nm         = man_q;
        ne         = exp_q;

        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    state_d = StAlign;
                end
            end
            StAlign: begin
                sa_d = a_q[31];
                sb_d = ~b_q[31];
                // Logical shift by >= 24 already yields zero.
                if (ea >= eb) begin
                    ediff = ea - eb;
                    exp_d = ea;
                    ma_d  = ma;
                    mb_d  = mb >> ediff;
                end else begin
                    ediff = eb - ea;
                    exp_d = eb;
                    ma_d  = ma >> ediff;
                    mb_d  = mb;
                end
                special_d  = 1'b0;
                spec_res_d = '0;
                if (b_q[30:0] == 31'd0) begin
                    special_d  = 1'b1;
                    spec_res_d = a_q;
                end else if (a_q[30:0] == 31'd0) begin
                    special_d  = 1'b1;
                    spec_res_d = {~b_q[31], b_q[30:0]};
                end
                state_d = StArith;
            end
            StArith: begin
                if (sa_q == sb_q) begin
                    sum    = {1'b0, ma_q} + {1'b0, mb_q};
                    sign_d = sa_q;
                end else if (ma_q >= mb_q) begin
                    sum    = {1'b0, ma_q - mb_q};
                    sign_d = sa_q;
                end else begin
                    sum    = {1'b0, mb_q - ma_q};
                    sign_d = sb_q;
                end
                done_d = special_q;
                ovf_d  = 1'b0;
                if (sum == 25'd0) begin
                    man_d  = '0;
                    exp_d  = '0;
                    sign_d = 1'b0;
                    done_d = 1'b1;
                end else if (sum[24]) begin
                    man_d = sum[24:1];
                    exp_d = exp_q + 8'd1;
                    ovf_d = (exp_q >= 8'd254);
                end else begin
                    man_d = sum[23:0];
                end
                state_d = StNorm;
            end
            StNorm: begin
                for (int unsigned i = 0; i < NORM_BITS; i++) begin
                    if (!done_q && !nm[23] && (ne != 8'd0)) begin
                        nm = nm << 1;
                        ne = ne - 8'd1;
                    end
                end
                man_d = nm;
                exp_d = ne;
                if (done_q || nm[23] || (ne == 8'd0)) begin
                    state_d = StPack;
                end
            end
            StPack: begin
                // Assemble and register the result word.
                if (special_q) begin
                    diff_d = spec_res_q;
                end else if (SatEn && ovf_q) begin
                    diff_d = sign_q ? 32'hFF7F_FFFF : 32'h7F7F_FFFF;
                end else begin
                    diff_d = {sign_q, exp_q, man_q[22:0]};
                end
                state_d = StDone;
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            ma_q       <= '0;
            mb_q       <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            exp_q      <= '0;
            man_q      <= '0;
            sign_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            diff_q     <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ma_q       <= ma_d;
            mb_q       <= mb_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            exp_q      <= exp_d;
            man_q      <= man_d;
            sign_q     <= sign_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            diff_q     <= diff_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.diff      = diff_q;

endmodule

// File: tb/tb_fp32_sub_seq.sv
// Directed bench for fp32_sub_seq: two instances (NORM_BITS = 1 and 2) share the stimulus;
// results and accept-to-valid latencies are checked against hand-computed values.
module tb_fp32_sub_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a, b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp32_sub_seq_if bus1 ();
    fp32_sub_seq_if bus2 ();

    assign bus1.in_valid  = in_valid;
    assign bus1.a         = a;
    assign bus1.b         = b;
    assign bus1.out_ready = out_ready;
    assign bus2.in_valid  = in_valid;
    assign bus2.a         = a;
    assign bus2.b         = b;
    assign bus2.out_ready = out_ready;

    fp32_sub_seq #(.NORM_BITS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    fp32_sub_seq #(.NORM_BITS(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One transaction with out_ready held high; records first out_valid cycle per instance.
    task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] dv, input int lat1, input int lat2);
        int          l1, l2;
        logic [31:0] d1, d2;
        l1 = 0;
        l2 = 0;
        d1 = 32'hxxxx_xxxx;
        d2 = 32'hxxxx_xxxx;
        @(negedge clk);
        check_eq({tag, " in_ready"}, {31'd0, bus1.in_ready & bus2.in_ready}, 32'd1);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (l1 == 0 && bus1.out_valid) begin
                l1 = k;
                d1 = bus1.diff;
            end
            if (l2 == 0 && bus2.out_valid) begin
                l2 = k;
                d2 = bus2.diff;
            end
        end
        check_eq({tag, " diff n1"}, d1, dv);
        check_eq({tag, " diff n2"}, d2, dv);
        check_eq({tag, " lat n1"}, 32'(l1), 32'(lat1));
        check_eq({tag, " lat n2"}, 32'(l2), 32'(lat2));
    endtask

    initial begin
        logic [31:0] sat_exp;
        logic        seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst out_valid", {31'd0, bus1.out_valid}, 32'd0);
        check_eq("rst in_ready", {31'd0, bus1.in_ready}, 32'd1);
        check_eq("rst diff", bus1.diff, 32'd0);
        rst = 1'b0;

        do_op("3-1",      32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4, 4);
        do_op("1-0.75",   32'h3F80_0000, 32'h3F40_0000, 32'h3E80_0000, 5, 4);
        do_op("1-(-1)",   32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 4, 4);
        do_op("a==b",     32'h4120_0000, 32'h4120_0000, 32'h0000_0000, 4, 4);
        do_op("0-5",      32'h0000_0000, 32'h40A0_0000, 32'hC0A0_0000, 4, 4);
        do_op("5-(-0)",   32'h40A0_0000, 32'h8000_0000, 32'h40A0_0000, 4, 4);
        do_op("1-3",      32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 4, 4);
        // 23 normalization shifts: 3+23 and 3+ceil(23/2).
        do_op("long norm", 32'h3F80_0000, 32'h3F7F_FFFF, 32'h3400_0000, 26, 15);
        // Exponent reaches 0 before the leading one does.
        do_op("exp floor", 32'h00C0_0000, 32'h00A0_0000, 32'h0040_0000, 4, 4);
`ifdef FP_SUB_SAT_EN
        sat_exp = 32'h7F7F_FFFF;
`else
        sat_exp = 32'h7FFF_FFFF;
`endif
        do_op("overflow", 32'h7F7F_FFFF, 32'hFF7F_FFFF, sat_exp, 4, 4);

        // Backpressure: result held while out_ready is low, new operands ignored.
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'h4040_0000;
        b        = 32'h3F80_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seen     = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (!seen) begin
                @(posedge clk);
                #1;
                seen = bus1.out_valid;
            end
        end
        check_eq("bp valid", {31'd0, seen}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = k[0];
            a        = 32'h1234_5678 + 32'(k);
            b        = 32'h3F80_0000;
            @(posedge clk);
            #1;
            check_eq("bp hold valid", {31'd0, bus1.out_valid}, 32'd1);
            check_eq("bp hold diff", bus1.diff, 32'h4000_0000);
            check_eq("bp in_ready", {31'd0, bus1.in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp release valid", {31'd0, bus1.out_valid}, 32'd0);
        check_eq("bp release ready", {31'd0, bus1.in_ready}, 32'd1);

        // Reset while the NORM_BITS=1 instance is normalizing.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'h3F80_0000;
        b        = 32'h3F40_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid rst valid", {31'd0, bus1.out_valid}, 32'd0);
        check_eq("mid rst ready", {31'd0, bus1.in_ready}, 32'd1);
        check_eq("mid rst diff", bus1.diff, 32'd0);
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            seen = seen | bus1.out_valid | bus2.out_valid;
        end
        check_eq("mid rst no output", {31'd0, seen}, 32'd0);

        do_op("after rst", 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp32_sub_seq.md
Name: fp32_sub_seq

Overview:
- Multi-cycle IEEE-754 single-precision subtractor with valid/ready handshakes on input and output.
- Computes DIFF = A − B using the team's existing FP32 arithmetic conventions: truncation, hidden bit 0 for exponent 0, no NaN/Inf handling.
- Sits in the SNN neuron datapath as the decrement/leak path, complementing the combinational FP adder.
- Normalization is iterative (bounded shifts per cycle) to keep the critical path short.

Parameters:
- NORM_BITS, 1, maximum single-bit left-normalization steps per NORM cycle; legal values 1, 2, 4, 8.

Ports:
- CLK  input  1  clock, all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  operands A/B valid.
- IN_READY  output  1  block can accept operands (high only in IDLE).
- A  input  32  minuend, FP32.
- B  input  32  subtrahend, FP32.
- OUT_VALID  output  1  DIFF valid.
- OUT_READY  input  1  consumer accepts DIFF.
- DIFF  output  32  result A − B, FP32.

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Reset values:
  - OUT_VALID=0, DIFF=32'h0, IN_READY=1.
  - FSM goes to IDLE; all internal registers are cleared.
  - Reset mid-operation discards the in-flight operation with no output.
- States and transitions:
  - IDLE: IN_READY=1. On IN_VALID&&IN_READY, register A and B and go to ALIGN.
  - ALIGN (1 cycle):
    - Form mantissas {hidden, frac}, where hidden = (exp != 0).
    - Effective sign of B is ~B[31].
    - EXP_D = |EA − EB|; L_EXP = max(EA, EB).
    - The mantissa with the smaller exponent is shifted right by EXP_D (truncating; shift ≥ 24 gives 0). The other mantissa is unshifted.
    - Go to ARITH.
  - ARITH (1 cycle):
    - If sign A == effective sign B, add the 24-bit magnitudes into a 25-bit sum; sign = sign A.
    - Otherwise subtract the smaller aligned magnitude from the larger; sign comes from the larger.
    - If the 25-bit result is 0: set the result to +0 (sign 0) and flag done.
    - If bit 24 is set: shift right 1, L_EXP+1.
    - Go to NORM.
  - NORM:
    - Each cycle performs up to NORM_BITS steps. A step applies only while man[23]==0 and exp>0: man<<=1, exp−=1.
    - Exit to DONE at the end of the cycle in which man[23]==1, or exp==0, or the done flag is set.
    - Minimum 1 cycle in NORM.
  - DONE:
    - OUT_VALID=1; DIFF = {sign, exp, man[22:0]}, held stable.
    - On OUT_READY, drop OUT_VALID next cycle and return to IDLE.
- Special cases (decided in ALIGN, carried through at fixed latency, NORM takes 1 cycle):
  - B[30:0]==0: DIFF=A.
  - Otherwise, if A[30:0]==0: DIFF={~B[31], B[30:0]}.
- Latency:
  - Measured from the accepting edge to the edge where OUT_VALID rises: 3 + max(1, ceil(s/NORM_BITS)), where s is the number of left shifts needed.
  - Minimum is 4 cycles.
- Throughput: one operation in flight; IN_READY=0 from acceptance until return to IDLE.
- Exponent overflow:
  - Without the optional feature, the exponent field is the computed value modulo 256; no Inf is generated.
  - No exception flags.
- Backpressure: with OUT_READY low, the block stays in DONE indefinitely, with DIFF and OUT_VALID stable.
- Inputs A/B are ignored when not accepted.

Optional Feature:
- Macro: FP_SUB_SAT_EN.
- Defined: if the ARITH carry would make the exponent ≥ 255, DIFF saturates to a signed max finite value: 32'h7F7FFFFF if sign 0, 32'hFF7FFFFF if sign 1.
- Undefined: the exponent is written as computed (modulo 256); mantissa per the normal path.

Test Plan:
- A=0x40400000 (3.0), B=0x3F800000 (1.0), OUT_READY=1 → DIFF=0x40000000, OUT_VALID rises 4 cycles after acceptance.
- A=0x3F800000, B=0x3F400000 (0.75), NORM_BITS=1 → DIFF=0x3E800000 (0.25), latency 5; with NORM_BITS=2, latency 4.
- A=0x3F800000, B=0xBF800000 (carry path) → 0x40000000. Also A=B=0x41200000 → 0x00000000, latency 4.
- A=0x00000000, B=0x40A00000 → 0xC0A00000. Also A=0x40A00000, B=0x80000000 → 0x40A00000.
- Hold OUT_READY=0 for 10 cycles → DIFF/OUT_VALID stable, IN_READY=0, new IN_VALID pulses ignored. Assert RST during NORM → next cycle OUT_VALID=0, IN_READY=1, DIFF=0.
- A=0x7F7FFFFF, B=0xFF7FFFFF → 0x7F7FFFFF with FP_SUB_SAT_EN, 0x7FFFFFFF without.
